// File: rtl/prog_loader_if.sv
// Point-to-point buses for the boot loader: an incoming valid/ready byte stream
// and the instruction-memory write port.

interface byte_stream_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (output rx_data, output rx_valid, input  rx_ready);
   modport slave  (input  rx_data, input  rx_valid, output rx_ready);
endinterface

interface imem_wr_if #(
   parameter int unsigned ADDR_W = 16
);
   logic              imem_wEn;
   logic [ADDR_W-1:0] imem_waddr;
   logic [31:0]       imem_wdata;

   modport master (output imem_wEn, output imem_waddr, output imem_wdata);
   modport slave  (input  imem_wEn, input  imem_waddr, input  imem_wdata);
endinterface

// File: rtl/prog_loader.sv
// Boot-time program loader: unpacks a framed, XOR-checksummed byte stream into
// little-endian 32-bit words, writes them to instruction memory, then releases the core.

module prog_loader #(
   parameter int unsigned       ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int unsigned       MAX_WORDS = 1024
) (
   input  logic       clk,
   input  logic       rst,
   byte_stream_if.slave rx,
   imem_wr_if.master    imem,
   output logic       cpu_rst_n,
   output logic       done,
   output logic       error
);

   typedef enum logic [2:0] {
      S_SYNC,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA,
      S_CHK,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   state_t      state_q, state_d;
   logic [7:0]  len_lo_q;
   logic [15:0] len_q;
   logic [15:0] word_cnt_q;
   logic [1:0]  byte_cnt_q;
   logic [23:0] shift_q;
   logic [7:0]  csum_q;

   logic        accept;
   logic [15:0] len_n;
   logic        word_done;
   logic        last_word;

   assign accept    = rx.rx_valid && rx.rx_ready;
   assign len_n     = {rx.rx_data, len_lo_q};
   assign word_done = (byte_cnt_q == 2'd3);
   assign last_word = (word_cnt_q == len_q - 16'd1);

   // State register
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst) state_q <= S_SYNC;
      else      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      // NOTE: default assignment first so no path through the case infers a latch.
      state_d = state_q;
      case (state_q)
         S_SYNC:   if (accept && rx.rx_data == SYNC_BYTE) state_d = S_LEN_LO;
         S_LEN_LO: if (accept) state_d = S_LEN_HI;
         S_LEN_HI: begin
            if (accept) begin
               if (32'(len_n) > MAX_WORDS) state_d = S_ERR;
               else if (len_n == 16'd0)    state_d = S_CHK;
               else                        state_d = S_DATA;
            end
         end
         S_DATA:   if (accept && word_done && last_word) state_d = S_CHK;
         S_CHK: begin
            if (accept) state_d = (rx.rx_data == csum_q) ? S_DONE : S_ERR;
         end
         default:  state_d = state_q;
      endcase
   end

   // Moore outputs: DONE and ERR are terminal until reset
   always_comb begin
      rx.rx_ready = 1'b1;
      done        = 1'b0;
      error       = 1'b0;
      cpu_rst_n   = 1'b0;
      case (state_q)
         S_DONE: begin
            rx.rx_ready = 1'b0;
            done        = 1'b1;
            cpu_rst_n   = 1'b1;
         end
         S_ERR: begin
            rx.rx_ready = 1'b0;
            error       = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath: length capture, word assembly, checksum and write strobe.
   // The strobe is registered on the 4th byte's accepting edge, so the next byte
   // can be accepted during the write cycle without disturbing it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         len_lo_q        <= '0;
         len_q           <= '0;
         word_cnt_q      <= '0;
         byte_cnt_q      <= '0;
         shift_q         <= '0;
         csum_q          <= '0;
         imem.imem_wEn   <= 1'b0;
         imem.imem_waddr <= BASE_ADDR;
         imem.imem_wdata <= '0;
      end else begin
         imem.imem_wEn <= 1'b0;
         if (accept) begin
            case (state_q)
               S_LEN_LO: begin
                  len_lo_q <= rx.rx_data;
                  csum_q   <= csum_q ^ rx.rx_data;
               end
               S_LEN_HI: begin
                  len_q  <= len_n;
                  csum_q <= csum_q ^ rx.rx_data;
               end
               S_DATA: begin
                  csum_q     <= csum_q ^ rx.rx_data;
                  shift_q    <= {rx.rx_data, shift_q[23:8]};
                  byte_cnt_q <= byte_cnt_q + 2'd1;
                  if (word_done) begin
                     imem.imem_wEn   <= 1'b1;
                     imem.imem_wdata <= {rx.rx_data, shift_q};
                     imem.imem_waddr <= BASE_ADDR + (ADDR_W'(word_cnt_q) << 2);
                     word_cnt_q      <= word_cnt_q + 16'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: reset, good/bad checksum frames, oversize length,
// noise and stalls, and mid-frame reset.

module tb_prog_loader;

   logic clk;
   logic rst;
   logic cpu_rst_n;
   logic done;
   logic error;

   int n_checks = 0;
   int n_pass   = 0;
   int pulses   = 0;
   int base;

   byte_stream_if   rx_if ();
   imem_wr_if #(16) im_if ();

   prog_loader #(
      .ADDR_W   (16),
      .BASE_ADDR(16'h0000),
      .MAX_WORDS(1024)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .rx       (rx_if),
      .imem     (im_if),
      .cpu_rst_n(cpu_rst_n),
      .done     (done),
      .error    (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count write strobes away from the active edge
   always @(negedge clk) if (im_if.imem_wEn === 1'b1) pulses++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      rx_if.rx_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_if.rx_data  = b;
      rx_if.rx_valid = 1'b1;
      @(posedge clk);
      #1 rx_if.rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Sends one word LSB first with optional stall before each byte, then checks the strobe
   task automatic send_word(input string tag, input logic [31:0] w, input int gap,
                            input logic [15:0] exp_addr);
      for (int i = 0; i < 4; i++) begin
         if (gap > 0) idle(gap);
         send_byte(w[8*i +: 8]);
         if (i == 2) check({tag, "_wen_early"}, 32'(im_if.imem_wEn), 32'd0);
      end
      check({tag, "_wen"},   32'(im_if.imem_wEn), 32'd1);
      check({tag, "_waddr"}, 32'(im_if.imem_waddr), 32'(exp_addr));
      check({tag, "_wdata"}, im_if.imem_wdata, w);
   endtask

   task automatic check_done(input string tag);
      check({tag, "_done"},  32'(done), 32'd1);
      check({tag, "_error"}, 32'(error), 32'd0);
      check({tag, "_cpu"},   32'(cpu_rst_n), 32'd1);
      check({tag, "_ready"}, 32'(rx_if.rx_ready), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      rx_if.rx_valid = 1'b0;
      rx_if.rx_data  = 8'h00;

      // T1: reset state
      do_reset();
      check("t1_ready", 32'(rx_if.rx_ready), 32'd1);
      check("t1_cpu",   32'(cpu_rst_n), 32'd0);
      check("t1_done",  32'(done), 32'd0);
      check("t1_error", 32'(error), 32'd0);
      check("t1_wen",   32'(im_if.imem_wEn), 32'd0);
      check("t1_waddr", 32'(im_if.imem_waddr), 32'h0);
      check("t1_wdata", im_if.imem_wdata, 32'h0);

      // T2: good two-word frame, CSUM = 02^13^50^93^10 = C2
      base = pulses;
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      send_word("t2_w0", 32'h0050_0013, 0, 16'h0000);
      send_word("t2_w1", 32'h0010_0093, 0, 16'h0004);
      check("t2_cpu_before", 32'(cpu_rst_n), 32'd0);
      send_byte(8'hC2);
      check_done("t2");
      idle(3);
      check("t2_pulses", 32'(pulses - base), 32'd2);
      check("t2_sticky", 32'(done), 32'd1);

      // T3: same frame, bad CSUM
      do_reset();
      base = pulses;
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      send_word("t3_w0", 32'h0050_0013, 0, 16'h0000);
      send_word("t3_w1", 32'h0010_0093, 0, 16'h0004);
      send_byte(8'hC3);
      check("t3_error",  32'(error), 32'd1);
      check("t3_done",   32'(done), 32'd0);
      check("t3_cpu",    32'(cpu_rst_n), 32'd0);
      check("t3_ready",  32'(rx_if.rx_ready), 32'd0);
      idle(2);
      check("t3_pulses", 32'(pulses - base), 32'd2);
      check("t3_cpu_hold", 32'(cpu_rst_n), 32'd0);

      // T4: N = 0x0401 exceeds MAX_WORDS
      do_reset();
      base = pulses;
      send_byte(8'hA5); send_byte(8'h01);
      check("t4_error_early", 32'(error), 32'd0);
      send_byte(8'h04);
      check("t4_error", 32'(error), 32'd1);
      check("t4_done",  32'(done), 32'd0);
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h50); send_byte(8'h00);
      idle(2);
      check("t4_pulses", 32'(pulses - base), 32'd0);

      // T5: leading noise and stalls inside words
      do_reset();
      base = pulses;
      send_byte(8'h00); send_byte(8'hFF);
      idle(2);
      send_byte(8'hA5); idle(1); send_byte(8'h02); send_byte(8'h00);
      send_word("t5_w0", 32'h0050_0013, 2, 16'h0000);
      send_word("t5_w1", 32'h0010_0093, 1, 16'h0004);
      idle(3);
      send_byte(8'hC2);
      check_done("t5");
      check("t5_pulses", 32'(pulses - base), 32'd2);

      // T6: reset after 5 bytes, then full frame
      do_reset();
      base = pulses;
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h00);
      do_reset();
      idle(2);
      check("t6_no_write", 32'(pulses - base), 32'd0);
      check("t6_ready",    32'(rx_if.rx_ready), 32'd1);
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      send_word("t6_w0", 32'h0050_0013, 0, 16'h0000);
      send_word("t6_w1", 32'h0010_0093, 0, 16'h0004);
      send_byte(8'hC2);
      check_done("t6");
      check("t6_pulses", 32'(pulses - base), 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
